i2c_slave: RTL

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address: ACKs writes and streams bytes from tx_data on reads.
// SCL/SDA are oversampled by clk; the bus must run at least 8x slower than clk.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1100010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  state_t     r_state, w_state_next;
  logic [7:0] r_shift, w_shift_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic       r_phase, w_phase_next;
  logic       r_sda_oe, w_sda_oe_next;
  logic [7:0] r_rx_data, w_rx_data_next;
  logic       r_rx_valid, w_rx_valid_next;
  logic       r_tx_req, w_tx_req_next;
  logic       r_busy, w_busy_next;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_shift    <= 8'h00;
      r_cnt      <= 3'd0;
      r_phase    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_s1   <= scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_d    <= r_scl_s2;
      r_sda_s1   <= sda;
      r_sda_s2   <= r_sda_s1;
      r_sda_d    <= r_sda_s2;
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_cnt      <= w_cnt_next;
      r_phase    <= w_phase_next;
      r_sda_oe   <= w_sda_oe_next;
      r_rx_data  <= w_rx_data_next;
      r_rx_valid <= w_rx_valid_next;
      r_tx_req   <= w_tx_req_next;
      r_busy     <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_cnt_next      = r_cnt;
    w_phase_next    = r_phase;
    w_sda_oe_next   = r_sda_oe;
    w_rx_data_next  = r_rx_data;
    w_rx_valid_next = 1'b0;
    w_tx_req_next   = 1'b0;
    w_busy_next     = r_busy;

    case (r_state)
      S_ADDR: begin
        if (w_scl_rise) begin
          w_shift_next = {r_shift[6:0], r_sda_s2};
          w_cnt_next   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            // r_shift[6:0] now holds the full address; the R/W bit lands in bit 0.
            if (r_shift[6:0] == SLAVE_ADDR) begin
              w_state_next = S_ADDR_ACK;
              w_phase_next = 1'b0;
              w_busy_next  = 1'b1;
            end else begin
              w_state_next = S_WAIT_STOP;
            end
          end
        end
      end
      S_ADDR_ACK, S_WR_ACK: begin
        // phase 0: start driving ACK; phase 1: the fall that ends the ACK bit.
        if (w_scl_fall) begin
          if (!r_phase) begin
            w_sda_oe_next = 1'b1;
            w_phase_next  = 1'b1;
          end else begin
            w_phase_next = 1'b0;
            w_cnt_next   = 3'd0;
            if (r_state == S_ADDR_ACK && r_shift[0]) begin
              w_state_next  = S_RD_BYTE;
              w_tx_req_next = 1'b1;
              w_shift_next  = {tx_data[6:0], 1'b0};
              w_sda_oe_next = ~tx_data[7];
            end else begin
              w_state_next  = S_WR_BYTE;
              w_sda_oe_next = 1'b0;
            end
          end
        end
      end
      S_WR_BYTE: begin
        if (w_scl_rise) begin
          w_shift_next = {r_shift[6:0], r_sda_s2};
          w_cnt_next   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_rx_data_next  = {r_shift[6:0], r_sda_s2};
            w_rx_valid_next = 1'b1;
            w_state_next    = S_WR_ACK;
            w_phase_next    = 1'b0;
          end
        end
      end
      S_RD_BYTE: begin
        // Bit 7 went out on entry, so falls 1..7 drive bits 6..0 and fall 8 releases.
        if (w_scl_fall) begin
          w_cnt_next = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_sda_oe_next = 1'b0;
            w_state_next  = S_RD_ACK;
            w_phase_next  = 1'b0;
          end else begin
            w_sda_oe_next = ~r_shift[7];
            w_shift_next  = {r_shift[6:0], 1'b0};
          end
        end
      end
      S_RD_ACK: begin
        if (w_scl_rise) begin
          if (r_sda_s2) w_state_next = S_WAIT_STOP;
          else          w_phase_next = 1'b1;
        end else if (w_scl_fall && r_phase) begin
          w_phase_next  = 1'b0;
          w_cnt_next    = 3'd0;
          w_state_next  = S_RD_BYTE;
          w_tx_req_next = 1'b1;
          w_shift_next  = {tx_data[6:0], 1'b0};
          w_sda_oe_next = ~tx_data[7];
        end
      end
      default: ;
    endcase

    // Bus conditions override everything, including a byte in flight.
    if (w_stop || w_start) begin
      w_state_next    = w_stop ? S_IDLE : S_ADDR;
      w_shift_next    = 8'h00;
      w_cnt_next      = 3'd0;
      w_phase_next    = 1'b0;
      w_sda_oe_next   = 1'b0;
      w_busy_next     = 1'b0;
      w_rx_data_next  = r_rx_data;
      w_rx_valid_next = 1'b0;
      w_tx_req_next   = 1'b0;
    end
  end

endmodule
